// File: rtl/ddr3_frame_reader_if.sv
// DDR3 local-interface read port plus VGA pixel FIFO write port.
// master = frame reader side, slave = controller/FIFO side.
interface ddr3_frame_reader_if #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 128
);

  logic              ddr3_avl_ready;
  logic              ddr3_avl_burstbegin;
  logic [2:0]        ddr3_avl_size;
  logic              ddr3_avl_read_req;
  logic [ADDR_W-1:0] ddr3_avl_addr;
  logic              ddr3_avl_read_data_valid;
  logic [DATA_W-1:0] ddr3_avl_read_data;
  logic              fifo_wr_en;
  logic [DATA_W-1:0] fifo_wr_data;
  logic [8:0]        fifo_used;

  modport master (
    input  ddr3_avl_ready,
    input  ddr3_avl_read_data_valid,
    input  ddr3_avl_read_data,
    input  fifo_used,
    output ddr3_avl_burstbegin,
    output ddr3_avl_size,
    output ddr3_avl_read_req,
    output ddr3_avl_addr,
    output fifo_wr_en,
    output fifo_wr_data
  );

  modport slave (
    output ddr3_avl_ready,
    output ddr3_avl_read_data_valid,
    output ddr3_avl_read_data,
    output fifo_used,
    input  ddr3_avl_burstbegin,
    input  ddr3_avl_size,
    input  ddr3_avl_read_req,
    input  ddr3_avl_addr,
    input  fifo_wr_en,
    input  fifo_wr_data
  );

endinterface

// File: rtl/ddr3_frame_reader.sv
// Frame fetch master: bursts a frame from DDR3 into the VGA FIFO.
// Bursts are gated by FIFO credit so the FIFO never overflows.
module ddr3_frame_reader #(
  parameter int ADDR_W       = 26,
  parameter int DATA_W       = 128,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int PIX_PER_WORD = 4,
  parameter int BURST_LEN    = 4,
  parameter int FIFO_DEPTH   = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] frame_base,
  ddr3_frame_reader_if.master bus,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun_err
);

  localparam int WORDS  = H_ACTIVE * V_ACTIVE / PIX_PER_WORD;
  localparam int BURSTS = WORDS / BURST_LEN;
  localparam int BC_W   = $clog2(BURSTS + 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN
  } state_t;

  state_t            state;
  logic [BC_W-1:0]   burst_cnt;
  logic [8:0]        out_cnt;
  logic [ADDR_W-1:0] next_addr;
  logic [10:0]       need;
  logic              credit_ok;
  logic              accept;
  logic              last_burst;
  logic              all_issued;
  logic              dec;

  assign bus.ddr3_avl_size = 3'(BURST_LEN);

  // Words in FIFO plus words still owed must leave room for a burst.
  assign need = {2'b0, bus.fifo_used}
              + {2'b0, out_cnt}
              + 11'(BURST_LEN);
  assign credit_ok  = need <= 11'(FIFO_DEPTH);
  assign accept     = (state == REQ)
                    && bus.ddr3_avl_read_req
                    && bus.ddr3_avl_ready;
  assign last_burst = burst_cnt == BC_W'(BURSTS - 1);
  assign all_issued = burst_cnt == BC_W'(BURSTS);
  assign dec        = bus.fifo_wr_en && (out_cnt != 9'd0);

  // Frame sequencing, burst issue and request handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                   <= IDLE;
      burst_cnt               <= '0;
      next_addr               <= '0;
      busy                    <= 1'b0;
      frame_done              <= 1'b0;
      overrun_err             <= 1'b0;
      bus.ddr3_avl_read_req   <= 1'b0;
      bus.ddr3_avl_burstbegin <= 1'b0;
      bus.ddr3_avl_addr       <= '0;
    end else begin
      frame_done <= 1'b0;
      if (frame_start && busy) begin
        overrun_err <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (frame_start && enable) begin
            next_addr <= frame_base;
            burst_cnt <= '0;
            busy      <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (bus.ddr3_avl_read_req) begin
            bus.ddr3_avl_burstbegin <= 1'b0;
            if (bus.ddr3_avl_ready) begin
              bus.ddr3_avl_read_req <= 1'b0;
              next_addr <= next_addr
                         + ADDR_W'(BURST_LEN);
              burst_cnt <= burst_cnt + 1'b1;
              if (last_burst || !enable) begin
                state <= DRAIN;
              end
            end
          end else if (!enable) begin
            state <= DRAIN;
          end else if (credit_ok) begin
            bus.ddr3_avl_read_req   <= 1'b1;
            bus.ddr3_avl_burstbegin <= 1'b1;
            bus.ddr3_avl_addr       <= next_addr;
          end
        end
        DRAIN: begin
          if (out_cnt == 9'd0 && !bus.fifo_wr_en) begin
            frame_done <= all_issued;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outstanding words: +BURST_LEN per accept, -1 per FIFO write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_cnt <= '0;
    end else begin
      out_cnt <= out_cnt
               + (accept ? 9'(BURST_LEN) : 9'd0)
               - (dec ? 9'd1 : 9'd0);
    end
  end

  // Return data is registered straight into the FIFO write port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.fifo_wr_en   <= 1'b0;
      bus.fifo_wr_data <= '0;
    end else begin
      bus.fifo_wr_en <= bus.ddr3_avl_read_data_valid;
      if (bus.ddr3_avl_read_data_valid) begin
        bus.fifo_wr_data <= bus.ddr3_avl_read_data;
      end
    end
  end

endmodule

// File: tb/tb_ddr3_frame_reader.sv
// Directed bench for ddr3_frame_reader on a 16-word frame.
// Responder returns word address as data, 3 cycles after accept.
module tb_ddr3_frame_reader;

  localparam int AW = 26;
  localparam int DW = 128;

  typedef struct {
    int          due;
    logic [AW-1:0] a;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          frame_start = 1'b0;
  logic [AW-1:0] frame_base = '0;
  logic          busy;
  logic          frame_done;
  logic          overrun_err;

  int n_chk = 0;
  int n_err = 0;

  logic          rnd_on = 1'b1;
  int            stall_at = -1;
  int            stall_len = 0;
  int            stall_cyc = 0;
  int            stall_seen = 0;
  int            done_cnt = 0;
  int            cyc = 0;
  logic          prev_req = 1'b0;
  logic          prev_acc = 1'b0;
  logic          prev_busy = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  logic [AW-1:0] acc_q[$];
  logic [DW-1:0] wr_q[$];
  beat_t         beat_q[$];

  ddr3_frame_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ddr3_frame_reader #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .H_ACTIVE(16),
    .V_ACTIVE(4),
    .PIX_PER_WORD(4),
    .BURST_LEN(4),
    .FIFO_DEPTH(256)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .frame_start(frame_start),
    .frame_base(frame_base),
    .bus(bus),
    .busy(busy),
    .frame_done(frame_done),
    .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  task automatic check(string tag,
                       logic [DW-1:0] got,
                       logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  // Protocol monitor and memory responder.
  always @(negedge clk) begin
    if (!reset_n) begin
      if (rnd_on) begin
        bus.ddr3_avl_ready = 1'($urandom);
        bus.ddr3_avl_read_data_valid = 1'($urandom);
        bus.ddr3_avl_read_data =
          {$urandom, $urandom, $urandom, $urandom};
      end else begin
        bus.ddr3_avl_ready = 1'b0;
        bus.ddr3_avl_read_data_valid = 1'b0;
        bus.ddr3_avl_read_data = '0;
      end
      prev_req = 1'b0;
      prev_acc = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (bus.ddr3_avl_read_req && !prev_req)
        check("bb_first", bus.ddr3_avl_burstbegin, 1);
      if (bus.ddr3_avl_read_req && prev_req) begin
        check("bb_hold", bus.ddr3_avl_burstbegin, 0);
        check("addr_hold", bus.ddr3_avl_addr, prev_addr);
      end
      if (prev_acc)
        check("req_gap", bus.ddr3_avl_read_req, 0);
      if (bus.fifo_wr_en)
        wr_q.push_back(bus.fifo_wr_data);
      if (frame_done) begin
        done_cnt++;
        check("done_busy", {prev_busy, busy}, 2'b10);
      end
      if (bus.ddr3_avl_read_req && acc_q.size() == stall_at
          && stall_cyc < stall_len) begin
        bus.ddr3_avl_ready = 1'b0;
        stall_cyc++;
        stall_seen++;
      end else begin
        bus.ddr3_avl_ready = 1'b1;
      end
      if (bus.ddr3_avl_read_req && bus.ddr3_avl_ready) begin
        acc_q.push_back(bus.ddr3_avl_addr);
        for (int k = 0; k < 4; k++) begin
          beat_t b;
          b.due = cyc + 3 + k;
          b.a = bus.ddr3_avl_addr + AW'(k);
          beat_q.push_back(b);
        end
        stall_cyc = 0;
      end
      if (beat_q.size() != 0 && beat_q[0].due <= cyc) begin
        bus.ddr3_avl_read_data_valid = 1'b1;
        bus.ddr3_avl_read_data = DW'(beat_q[0].a);
        void'(beat_q.pop_front());
      end else begin
        bus.ddr3_avl_read_data_valid = 1'b0;
        bus.ddr3_avl_read_data = '0;
      end
      prev_req = bus.ddr3_avl_read_req;
      prev_addr = bus.ddr3_avl_addr;
      prev_acc = bus.ddr3_avl_read_req && bus.ddr3_avl_ready;
      prev_busy = busy;
      cyc++;
    end
  end

  task automatic start_frame(logic [AW-1:0] base);
    frame_base = base;
    frame_start = 1'b1;
    step;
    frame_start = 1'b0;
    check("busy_set", busy, 1);
  endtask

  task automatic wait_idle(string tag);
    for (int i = 0; i < 400 && busy; i++) step;
    check(tag, busy, 0);
  endtask

  task automatic check_frame(logic [AW-1:0] base,
                             int a0, int w0, int nb);
    logic [AW-1:0] e;
    check("n_bursts", acc_q.size() - a0, nb);
    for (int b = 0; b < nb; b++) begin
      e = base + AW'(4 * b);
      check("burst_addr", acc_q[a0 + b], e);
    end
    check("n_words", wr_q.size() - w0, 4 * nb);
    for (int k = 0; k < 4 * nb; k++) begin
      e = base + AW'(k);
      check("word", wr_q[w0 + k], DW'(e));
    end
  endtask

  initial begin
    int a0;
    int w0;
    int d0;
    int s0;
    bus.fifo_used = '0;

    repeat (4) begin
      step;
      enable = 1'($urandom);
      frame_start = 1'($urandom);
      frame_base = AW'($urandom);
      bus.fifo_used = 9'($urandom);
      check("rst_req", bus.ddr3_avl_read_req, 0);
      check("rst_bb", bus.ddr3_avl_burstbegin, 0);
      check("rst_wr", bus.fifo_wr_en, 0);
      check("rst_busy", busy, 0);
      check("rst_done", frame_done, 0);
      check("rst_ovr", overrun_err, 0);
      check("rst_size", bus.ddr3_avl_size, 3'd4);
    end
    step;
    rnd_on = 1'b0;
    enable = 1'b1;
    frame_start = 1'b0;
    frame_base = '0;
    bus.fifo_used = '0;
    step;
    reset_n = 1'b1;
    step;

    a0 = acc_q.size(); w0 = wr_q.size(); d0 = done_cnt;
    start_frame(26'h100);
    wait_idle("f1_timeout");
    step;
    check_frame(26'h100, a0, w0, 4);
    check("f1_done", done_cnt - d0, 1);
    check("f1_ovr", overrun_err, 0);

    a0 = acc_q.size(); w0 = wr_q.size(); d0 = done_cnt;
    s0 = stall_seen;
    stall_at = a0 + 1;
    stall_len = 5;
    start_frame(26'h200);
    repeat (6) step;
    frame_base = 26'h3333;
    frame_start = 1'b1;
    step;
    frame_start = 1'b0;
    check("ovr_set", overrun_err, 1);
    wait_idle("f2_timeout");
    step;
    stall_at = -1;
    check_frame(26'h200, a0, w0, 4);
    check("stall_cyc", stall_seen - s0, 5);
    check("ovr_sticky", overrun_err, 1);
    check("f2_done", done_cnt - d0, 1);

    a0 = acc_q.size(); w0 = wr_q.size(); d0 = done_cnt;
    bus.fifo_used = 9'd253;
    start_frame(26'h300);
    repeat (10) step;
    check("credit_blk", bus.ddr3_avl_read_req, 0);
    check("credit_nacc", acc_q.size() - a0, 0);
    bus.fifo_used = 9'd252;
    step;
    check("credit_go", bus.ddr3_avl_read_req, 1);
    bus.fifo_used = 9'd0;
    wait_idle("f3_timeout");
    step;
    check_frame(26'h300, a0, w0, 4);
    check("f3_done", done_cnt - d0, 1);

    a0 = acc_q.size(); w0 = wr_q.size(); d0 = done_cnt;
    start_frame(26'h3FFFFFC);
    wait_idle("f4_timeout");
    step;
    check_frame(26'h3FFFFFC, a0, w0, 4);
    check("f4_done", done_cnt - d0, 1);

    a0 = acc_q.size(); w0 = wr_q.size(); d0 = done_cnt;
    start_frame(26'h500);
    for (int i = 0; i < 100 && acc_q.size() == a0; i++)
      step;
    enable = 1'b0;
    wait_idle("f5_timeout");
    repeat (10) step;
    check_frame(26'h500, a0, w0, 1);
    check("f5_nodone", done_cnt - d0, 0);
    check("f5_req", bus.ddr3_avl_read_req, 0);

    frame_start = 1'b1;
    step;
    frame_start = 1'b0;
    check("start_dis", busy, 0);
    step;
    check("start_dis2", busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
